// File: rtl/sig_debounce_if.sv
// sig_debounce_if: raw input, glitch clear and conditioned outputs of the debouncer
interface sig_debounce_if #(
  parameter int GLITCH_W = 8
);
  logic                raw_in;
  logic                glitch_clr;
  logic                sig_level;
  logic                rise_pulse;
  logic                fall_pulse;
  logic [GLITCH_W-1:0] glitch_count;
  modport master (output raw_in, glitch_clr, input sig_level, rise_pulse, fall_pulse, glitch_count);
  modport slave (input raw_in, glitch_clr, output sig_level, rise_pulse, fall_pulse, glitch_count);
endinterface

// File: rtl/sig_debounce.sv
// sig_debounce: 2-flop synchronizer plus tick-sampled stability filter with edge pulses
// and a saturating count of rejected transitions.
module sig_debounce #(
  parameter int SAMPLE_DIV     = 4,
  parameter int STABLE_SAMPLES = 3,
  parameter int GLITCH_W       = 8
) (
  input logic           clk,
  input logic           rst,
  sig_debounce_if.slave bus
);
  localparam int TW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  localparam int SW = STABLE_SAMPLES > 1 ? $clog2(STABLE_SAMPLES) : 1;
  logic                sync1_q, sync2_q;
  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]       stable_q, stable_d;
  logic                level_q, level_d, rise_q, rise_d, fall_q, fall_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                tick, diff, accept, reject;
  always_comb begin
    tick       = tick_cnt_q == TW'(SAMPLE_DIV - 1);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    diff       = sync2_q != level_q;
    accept     = tick && diff && stable_q == SW'(STABLE_SAMPLES - 1);
    reject     = tick && !diff && stable_q != '0;
    stable_d   = (accept || reject) ? '0 : (tick && diff) ? stable_q + SW'(1) : stable_q;
    level_d    = accept ? sync2_q : level_q;
    rise_d     = accept && sync2_q;
    fall_d     = accept && !sync2_q;
    // clear takes priority over a same-cycle rejection
    glitch_d   = bus.glitch_clr ? '0 : (reject && !(&glitch_q)) ? glitch_q + GLITCH_W'(1) : glitch_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      tick_cnt_q <= '0;
      stable_q   <= '0;
      level_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      glitch_q   <= '0;
    end else begin
      sync1_q    <= bus.raw_in;
      sync2_q    <= sync1_q;
      tick_cnt_q <= tick_cnt_d;
      stable_q   <= stable_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      glitch_q   <= glitch_d;
    end
  end
  assign bus.sig_level    = level_q;
  assign bus.rise_pulse   = rise_q;
  assign bus.fall_pulse   = fall_q;
  assign bus.glitch_count = glitch_q;
endmodule

// File: tb/tb_sig_debounce.sv
// tb_sig_debounce: directed checks of three debouncer configurations sharing one clock
module tb_sig_debounce;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  sig_debounce_if #(.GLITCH_W(8)) b1 ();
  sig_debounce_if #(.GLITCH_W(2)) b5 ();
  sig_debounce_if #(.GLITCH_W(8)) b6 ();
  sig_debounce #(.SAMPLE_DIV(1), .STABLE_SAMPLES(3), .GLITCH_W(8)) u1 (.clk(clk), .rst(rst), .bus(b1));
  sig_debounce #(.SAMPLE_DIV(1), .STABLE_SAMPLES(3), .GLITCH_W(2)) u5 (.clk(clk), .rst(rst), .bus(b5));
  sig_debounce #(.SAMPLE_DIV(4), .STABLE_SAMPLES(3), .GLITCH_W(8)) u6 (.clk(clk), .rst(rst), .bus(b6));
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    int lat, rises, falls;
    logic [4:0] pat;
    logic [1:0] gexp [5];
    pat = 5'b10010;
    gexp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    b1.raw_in = 0; b1.glitch_clr = 0;
    b5.raw_in = 0; b5.glitch_clr = 0;
    b6.raw_in = 0; b6.glitch_clr = 0;
    step(2);
    rst = 0;
    chk("rst_level", b1.sig_level, 0);
    chk("rst_rise", b1.rise_pulse, 0);
    chk("rst_fall", b1.fall_pulse, 0);
    chk("rst_glitch", b1.glitch_count, 0);
    chk("rst_glitch6", b6.glitch_count, 0);
    // async reset while a rise is two samples in
    step(1);
    b1.raw_in = 1;
    step(4);
    #2 rst = 1;
    #1;
    chk("arst_level", b1.sig_level, 0);
    chk("arst_rise", b1.rise_pulse, 0);
    #1 rst = 0;
    step(4);
    chk("post_rst_k4_level", b1.sig_level, 0);
    step(1);
    chk("post_rst_k5_level", b1.sig_level, 1);
    chk("post_rst_k5_rise", b1.rise_pulse, 1);
    chk("post_rst_k5_fall", b1.fall_pulse, 0);
    step(1);
    chk("k6_rise", b1.rise_pulse, 0);
    chk("k6_level", b1.sig_level, 1);
    chk("k6_glitch", b1.glitch_count, 0);
    // clean fall
    b1.raw_in = 0;
    step(4);
    chk("fall_k4_level", b1.sig_level, 1);
    chk("fall_k4_pulse", b1.fall_pulse, 0);
    step(1);
    chk("fall_k5_level", b1.sig_level, 0);
    chk("fall_k5_pulse", b1.fall_pulse, 1);
    chk("fall_k5_rise", b1.rise_pulse, 0);
    step(1);
    chk("fall_k6_pulse", b1.fall_pulse, 0);
    // two-cycle glitch is rejected
    b1.raw_in = 1;
    step(2);
    b1.raw_in = 0;
    step(2);
    chk("gl_k4_count", b1.glitch_count, 0);
    chk("gl_k4_level", b1.sig_level, 0);
    step(1);
    chk("gl_k5_count", b1.glitch_count, 1);
    chk("gl_k5_level", b1.sig_level, 0);
    chk("gl_k5_rise", b1.rise_pulse, 0);
    // level pattern 1,0,0,1,0 held 6 cycles each
    rises = 0;
    falls = 0;
    for (int i = 4; i >= 0; i--) begin
      b1.raw_in = pat[i];
      for (int c = 0; c < 6; c++) begin
        step(1);
        rises += int'(b1.rise_pulse);
        falls += int'(b1.fall_pulse);
        chk("pat_excl", b1.rise_pulse & b1.fall_pulse, 0);
      end
      chk("pat_level", b1.sig_level, pat[i]);
    end
    chk("pat_rises", rises, 2);
    chk("pat_falls", falls, 2);
    // saturating glitch counter, GLITCH_W=2
    for (int g = 0; g < 5; g++) begin
      b5.raw_in = 1;
      step(2);
      b5.raw_in = 0;
      step(3);
      chk("sat_count", b5.glitch_count, gexp[g]);
    end
    b5.raw_in = 1;
    step(2);
    b5.raw_in = 0;
    step(2);
    b5.glitch_clr = 1;
    step(1);
    b5.glitch_clr = 0;
    chk("clr_wins", b5.glitch_count, 0);
    chk("clr_level", b5.sig_level, 0);
    // default config at four tick phases
    for (int p = 0; p < 4; p++) begin
      for (int w = 0; w < 4 && (cyc % 4) != p; w++) step(1);
      b6.raw_in = 1;
      lat = 0;
      rises = 0;
      do begin
        step(1);
        lat++;
        rises += int'(b6.rise_pulse);
      end while (!b6.sig_level && lat < 30);
      chk("lat_in_range", (lat >= 11 && lat <= 14), 1);
      for (int c = 0; c < 4; c++) begin
        step(1);
        rises += int'(b6.rise_pulse);
      end
      chk("one_rise", rises, 1);
      b6.raw_in = 0;
      step(20);
      chk("d_fall_level", b6.sig_level, 0);
    end
    chk("d_glitch", b6.glitch_count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
